// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the PC, fills a one-line buffer from the
// I-cache and pushes {order, pc, inst} into the instruction queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'haaaaa000,
    parameter int          ORDER_W  = 64,
    parameter int          QWIDTH   = ORDER_W + 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       icache_addr,
    output logic [3:0]        icache_rmask,
    input  logic [31:0]       icache_rdata,
    input  logic [255:0]      icache_line,
    input  logic              icache_resp,
    input  logic              iq_full,
    output logic              iq_enqueue,
    output logic [QWIDTH-1:0] iq_data,
    output logic [31:0]       fetch_pc
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [ORDER_W-1:0]   order_q, order_d;
    logic [26:0]          lb_tag_q, lb_tag_d;
    logic [255:0]         lb_line_q, lb_line_d;
    logic                 lb_valid_q, lb_valid_d;
    logic [31:0]          addr_q, addr_d;
    logic [3:0]           rmask_q, rmask_d;

    logic                 lb_hit;
    logic                 resp_match;
    logic [31:0]          lb_word;
    logic [31:0]          resp_word;
    logic [31:0]          enq_word;
    logic [31:0]          pc_inc;
    logic [ORDER_W-1:0]   order_inc;

    // The word port and the low PC bits of the line tag are never consumed.
    logic                 unused_ok;
    assign unused_ok = ^icache_rdata;

    assign lb_hit     = lb_valid_q && (pc_q[31:5] == lb_tag_q);
    assign resp_match = (addr_q[31:5] == pc_q[31:5]);
    assign lb_word    = lb_line_q[{pc_q[4:2], 5'b0} +: 32];
    assign resp_word  = icache_line[{pc_q[4:2], 5'b0} +: 32];
    assign pc_inc     = pc_q + 32'd4;
    assign order_inc  = order_q + ORDER_W'(1);

    assign icache_addr  = addr_q;
    assign icache_rmask = rmask_q;
    assign fetch_pc     = pc_q;
    assign iq_data      = {order_q, pc_q, enq_word};

    // Next-state, line-buffer fill and enqueue decision; redirect beats enqueue.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        order_d    = order_q;
        lb_tag_d   = lb_tag_q;
        lb_line_d  = lb_line_q;
        lb_valid_d = lb_valid_q;
        addr_d     = addr_q;
        rmask_d    = rmask_q;
        iq_enqueue = 1'b0;
        enq_word   = lb_word;

        unique case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (lb_hit) begin
                    if (!iq_full) begin
                        iq_enqueue = 1'b1;
                        pc_d       = pc_inc;
                        order_d    = order_inc;
                    end
                end else begin
                    addr_d  = {pc_q[31:5], 5'b0};
                    rmask_d = 4'hf;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                enq_word = resp_word;
                if (icache_resp) begin
                    lb_tag_d   = addr_q[31:5];
                    lb_line_d  = icache_line;
                    lb_valid_d = 1'b1;
                    rmask_d    = 4'h0;
                    state_d    = ST_FETCH;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (!iq_full && resp_match) begin
                        iq_enqueue = 1'b1;
                        pc_d       = pc_inc;
                        order_d    = order_inc;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (icache_resp) begin
                    lb_tag_d   = addr_q[31:5];
                    lb_line_d  = icache_line;
                    lb_valid_d = 1'b1;
                    rmask_d    = 4'h0;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            order_q    <= '0;
            lb_tag_q   <= '0;
            lb_line_q  <= '0;
            lb_valid_q <= 1'b0;
            addr_q     <= '0;
            rmask_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            order_q    <= order_d;
            lb_tag_q   <= lb_tag_d;
            lb_line_q  <= lb_line_d;
            lb_valid_q <= lb_valid_d;
            addr_q     <= addr_d;
            rmask_q    <= rmask_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cold miss, streaming hits, queue stall,
// redirects (in-line and during a miss) and reset during an outstanding miss.
module tb_fetch_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [31:0]  icache_addr;
    logic [3:0]   icache_rmask;
    logic [31:0]  icache_rdata;
    logic [255:0] icache_line;
    logic         icache_resp;
    logic         iq_full;
    logic         iq_enqueue;
    logic [127:0] iq_data;
    logic [31:0]  fetch_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_addr    (icache_addr),
        .icache_rmask   (icache_rmask),
        .icache_rdata   (icache_rdata),
        .icache_line    (icache_line),
        .icache_resp    (icache_resp),
        .iq_full        (iq_full),
        .iq_enqueue     (iq_enqueue),
        .iq_data        (iq_data),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return {16'hc0de, pc[15:0]};
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[32*i +: 32] = mk_inst({base[31:5], 5'b0} + 32'(4 * i));
        return l;
    endfunction

    function automatic logic [127:0] ent(input logic [63:0] o,
                                         input logic [31:0] pc);
        return {o, pc, mk_inst(pc)};
    endfunction

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled on the falling edge, mid-cycle.
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        icache_rdata   = 32'hdeadbeef;
        icache_line    = '0;
        icache_resp    = 1'b0;
        iq_full        = 1'b0;
        tick();
        tick();
        mid();
        check("rst_rmask", 128'(icache_rmask), 128'h0);
        check("rst_addr", 128'(icache_addr), 128'h0);
        check("rst_enq", 128'(iq_enqueue), 128'h0);
        check("rst_pc", 128'(fetch_pc), 128'haaaaa000);

        // Cold miss: request one cycle after leaving reset.
        tick();
        rst = 1'b0;
        mid();
        check("cold_enq", 128'(iq_enqueue), 128'h0);
        tick();
        mid();
        check("req0_rmask", 128'(icache_rmask), 128'hf);
        check("req0_addr", 128'(icache_addr), 128'haaaaa000);
        tick();
        tick();
        mid();
        check("wait_rmask", 128'(icache_rmask), 128'hf);
        check("wait_enq", 128'(iq_enqueue), 128'h0);
        tick();
        icache_resp = 1'b1;
        icache_line = mk_line(32'haaaaa000);
        mid();
        check("byp_enq", 128'(iq_enqueue), 128'h1);
        check("byp_data", iq_data, ent(64'd0, 32'haaaaa000));
        tick();
        icache_resp = 1'b0;
        icache_line = '0;

        // Remaining seven words stream back-to-back from the buffer.
        for (int i = 1; i < 8; i++) begin
            mid();
            check("hit_enq", 128'(iq_enqueue), 128'h1);
            check("hit_data", iq_data,
                  ent(64'(i), 32'haaaaa000 + 32'(4 * i)));
            tick();
        end
        mid();
        check("cross_enq", 128'(iq_enqueue), 128'h0);
        check("cross_pc", 128'(fetch_pc), 128'haaaaa020);
        tick();
        mid();
        check("req1_rmask", 128'(icache_rmask), 128'hf);
        check("req1_addr", 128'(icache_addr), 128'haaaaa020);
        tick();
        icache_resp = 1'b1;
        icache_line = mk_line(32'haaaaa020);
        mid();
        check("byp1_data", iq_data, ent(64'd8, 32'haaaaa020));
        tick();
        icache_resp = 1'b0;

        // Queue full on a hit freezes pc and order.
        iq_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("full_enq", 128'(iq_enqueue), 128'h0);
            tick();
        end
        mid();
        check("full_pc", 128'(fetch_pc), 128'haaaaa024);
        iq_full = 1'b0;
        #1;
        check("resume_enq", 128'(iq_enqueue), 128'h1);
        check("resume_data", iq_data, ent(64'd9, 32'haaaaa024));
        tick();

        // Redirect inside the buffered line.
        redirect_valid = 1'b1;
        redirect_pc    = 32'haaaaa034;
        mid();
        check("redir_enq", 128'(iq_enqueue), 128'h0);
        tick();
        redirect_valid = 1'b0;
        mid();
        check("redir_hit", iq_data, ent(64'd10, 32'haaaaa034));
        check("redir_enq1", 128'(iq_enqueue), 128'h1);
        check("redir_rmask", 128'(icache_rmask), 128'h0);
        tick();
        mid();
        check("hit38", iq_data, ent(64'd11, 32'haaaaa038));
        tick();
        mid();
        check("hit3c", iq_data, ent(64'd12, 32'haaaaa03c));
        tick();
        tick();
        mid();
        check("req2_addr", 128'(icache_addr), 128'haaaaa040);

        // Redirect during WAIT: drain the old line, no enqueue.
        redirect_valid = 1'b1;
        redirect_pc    = 32'haaaaa100;
        #1;
        check("wredir_enq", 128'(iq_enqueue), 128'h0);
        tick();
        redirect_valid = 1'b0;
        mid();
        check("drain_pc", 128'(fetch_pc), 128'haaaaa100);
        check("drain_rmask", 128'(icache_rmask), 128'hf);
        check("drain_addr", 128'(icache_addr), 128'haaaaa040);
        tick();
        icache_resp = 1'b1;
        icache_line = mk_line(32'haaaaa040);
        mid();
        check("drain_enq", 128'(iq_enqueue), 128'h0);
        tick();
        icache_resp = 1'b0;
        mid();
        check("post_drain_rmask", 128'(icache_rmask), 128'h0);
        check("post_drain_enq", 128'(iq_enqueue), 128'h0);
        tick();
        mid();
        check("req3_rmask", 128'(icache_rmask), 128'hf);
        check("req3_addr", 128'(icache_addr), 128'haaaaa100);

        // Reset in WAIT; a late response must be ignored.
        tick();
        rst = 1'b1;
        tick();
        mid();
        check("mrst_rmask", 128'(icache_rmask), 128'h0);
        check("mrst_pc", 128'(fetch_pc), 128'haaaaa000);
        icache_resp = 1'b1;
        icache_line = mk_line(32'haaaaa000);
        #1;
        check("mrst_enq", 128'(iq_enqueue), 128'h0);
        tick();
        rst = 1'b0;
        mid();
        check("late_enq", 128'(iq_enqueue), 128'h0);
        tick();
        icache_resp = 1'b0;
        mid();
        check("lbinv_rmask", 128'(icache_rmask), 128'hf);
        check("lbinv_addr", 128'(icache_addr), 128'haaaaa000);
        tick();
        icache_resp = 1'b1;
        mid();
        check("rst_order", iq_data, ent(64'd0, 32'haaaaa000));
        tick();
        icache_resp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
